vga_display_timing: RTL and testbench

- Generates 640x480@60 VGA raster timing from the 100 MHz board clock.
- Outputs hCount, vCount and bright to the game/pixel block, and hSync/vSync to the connector.
- Also produces a programmable per-frame tick that the game-logic block uses to step object positions.
- It is the producer side of the hCount/vCount/bright interface that the pixel-colour logic consumes.

---
 rtl/vga_display_timing.sv | 100 ++++++++++
 tb/tb_vga_display_timing.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/vga_display_timing.sv
// VGA raster timing generator: pixel-rate divider, h/v position counters,
// registered sync/bright outputs and a programmable per-frame tick.
module vga_display_timing #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_START     = 144,
  parameter int unsigned H_END       = 783,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_START     = 35,
  parameter int unsigned V_END       = 514,
  parameter int unsigned TICK_FRAMES = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       frame_tick,
  output logic [7:0] frame_count
);

  localparam int unsigned DW = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [9:0]    H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_SYNC_C  = 10'(H_SYNC);
  localparam logic [9:0]    V_SYNC_C  = 10'(V_SYNC);
  localparam logic [9:0]    H_START_C = 10'(H_START);
  localparam logic [9:0]    H_END_C   = 10'(H_END);
  localparam logic [9:0]    V_START_C = 10'(V_START);
  localparam logic [9:0]    V_END_C   = 10'(V_END);
  localparam logic [7:0]    TICK_LAST = 8'(TICK_FRAMES - 1);

  logic [DW-1:0] div, div_next;
  logic [9:0]    h_next, v_next;
  logic [7:0]    tick_cnt;
  logic          frame_end;
  logic          tick_hit;

  always_comb begin
    div_next = (div == DIV_LAST) ? '0 : div + 1'b1;
  end

  always_comb begin
    h_next    = hCount;
    v_next    = vCount;
    frame_end = 1'b0;
    if (pix_en) begin
      if (hCount == H_LAST) begin
        h_next = '0;
        if (vCount == V_LAST) begin
          v_next    = '0;
          frame_end = 1'b1;
        end else begin
          v_next = vCount + 1'b1;
        end
      end else begin
        h_next = hCount + 1'b1;
      end
    end
    tick_hit = frame_end && (tick_cnt == TICK_LAST);
  end

  // Sync/bright decode the next position so they switch on the same edge as the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div         <= '0;
      pix_en      <= 1'b0;
      hCount      <= '0;
      vCount      <= '0;
      hSync       <= 1'b0;
      vSync       <= 1'b0;
      bright      <= 1'b0;
      frame_tick  <= 1'b0;
      frame_count <= '0;
      tick_cnt    <= '0;
    end else begin
      div        <= div_next;
      pix_en     <= (div_next == DIV_LAST);
      hCount     <= h_next;
      vCount     <= v_next;
      hSync      <= (h_next >= H_SYNC_C);
      vSync      <= (v_next >= V_SYNC_C);
      bright     <= (h_next >= H_START_C) && (h_next <= H_END_C) &&
                    (v_next >= V_START_C) && (v_next <= V_END_C);
      frame_tick <= tick_hit;
      if (frame_end) begin
        frame_count <= frame_count + 1'b1;
        tick_cnt    <= tick_hit ? '0 : tick_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_display_timing.sv
// Bench for vga_display_timing on a shrunken raster; outputs are predicted
// in closed form from the number of clocks elapsed since reset release.
module tb_vga_display_timing;

  localparam int unsigned CD  = 2;
  localparam int unsigned HT  = 10;
  localparam int unsigned HS  = 2;
  localparam int unsigned HB  = 3;
  localparam int unsigned HE  = 8;
  localparam int unsigned VT  = 6;
  localparam int unsigned VS  = 1;
  localparam int unsigned VB  = 2;
  localparam int unsigned VE  = 4;
  localparam int unsigned TF  = 3;
  localparam int unsigned FPX = HT * VT;
  localparam int unsigned FCK = FPX * CD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_en, hSync, vSync, bright, frame_tick;
  logic [9:0] hCount, vCount;
  logic [7:0] frame_count;

  int unsigned n = 0;
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned tick_seen = 0;

  vga_display_timing #(
    .CLK_DIV(CD), .H_TOTAL(HT), .H_SYNC(HS), .H_START(HB), .H_END(HE),
    .V_TOTAL(VT), .V_SYNC(VS), .V_START(VB), .V_END(VE), .TICK_FRAMES(TF)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hCount(hCount), .vCount(vCount),
    .hSync(hSync), .vSync(vSync), .bright(bright), .frame_tick(frame_tick),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // {pix_en, hCount, vCount, hSync, vSync, bright, frame_tick, frame_count}
  function automatic logic [32:0] model(input int unsigned clks);
    int unsigned p, h, v, fr;
    logic pe, tk;
    p  = clks / CD;
    h  = p % HT;
    v  = (p / HT) % VT;
    fr = p / FPX;
    pe = ((clks + 1) % CD) == 0;
    tk = (clks > 0) && (clks % CD == 0) && (p > 0) && (p % FPX == 0) && ((fr % TF) == 0);
    return {pe, 10'(h), 10'(v), (h >= HS), (v >= VS),
            (h >= HB && h <= HE && v >= VB && v <= VE), tk, 8'(fr % 256)};
  endfunction

  function automatic logic [32:0] actual();
    return {pix_en, hCount, vCount, hSync, vSync, bright, frame_tick, frame_count};
  endfunction

  task automatic check(input string name, input logic [32:0] exp);
    tests++;
    if (actual() !== exp) begin
      fails++;
      $display("FAIL %s n=%0d actual=%h required=%h", name, n, actual(), exp);
    end
  endtask

  task automatic check_int(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) n++;
    @(negedge clk);
    if (frame_tick) tick_seen++;
  endtask

  task automatic run_checked(input int unsigned k, input string name);
    for (int unsigned i = 0; i < k; i++) begin
      step();
      check(name, model(n));
    end
  endtask

  // Called at a negedge; outputs must clear without waiting for a clock.
  task automatic do_reset(input int unsigned hold);
    rst = 1'b1;
    #1;
    n = 0;
    check("rst_async", '0);
    for (int unsigned i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_hold", '0);
    end
    rst = 1'b0;
  endtask

  typedef struct {
    int unsigned at;
    logic        pe;
    logic [9:0]  h, v;
    logic        hs, vs, br, tk;
    logic [7:0]  fc;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{0,   1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1,   1'b1, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{2,   1'b0, 10'd1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{4,   1'b0, 10'd2, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{20,  1'b0, 10'd0, 10'd1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{46,  1'b0, 10'd3, 10'd2, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[6]  = '{56,  1'b0, 10'd8, 10'd2, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[7]  = '{58,  1'b0, 10'd9, 10'd2, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[8]  = '{96,  1'b0, 10'd8, 10'd4, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0};
    vecs[9]  = '{98,  1'b0, 10'd9, 10'd4, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[10] = '{100, 1'b0, 10'd0, 10'd5, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    vecs[11] = '{120, 1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};

    @(negedge clk);
    do_reset(2);

    for (int i = 0; i < 12; i++) begin
      while (n < vecs[i].at) step();
      check($sformatf("vec%0d", i),
            {vecs[i].pe, vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].vs,
             vecs[i].br, vecs[i].tk, vecs[i].fc});
    end

    // Seven frames with a tick every third frame.
    do_reset(2);
    tick_seen = 0;
    run_checked(7 * FCK, "frames7");
    check_int("tick_count7", tick_seen, 2);
    check_int("frame_count7", frame_count, 7);

    // Reset in the middle of a frame; tick must wait for whole frames again.
    run_checked(68, "to_mid");
    check_int("mid_h", hCount, 4);
    check_int("mid_v", vCount, 3);
    do_reset(2);
    tick_seen = 0;
    run_checked(2 * FCK, "after_mid_rst");
    check_int("tick_after_rst", tick_seen, 0);

    // Frame counter wrap.
    do_reset(1);
    tick_seen = 0;
    run_checked(255 * FCK, "frames255");
    check_int("fc255", frame_count, 255);
    run_checked(FCK, "frame256");
    check_int("fc_wrap", frame_count, 0);
    check_int("tick_count256", tick_seen, 85);

    // Random run lengths with random reset interruptions.
    for (int i = 0; i < 20; i++) begin
      run_checked($urandom_range(1, 400), "random");
      if ($urandom_range(0, 3) == 0) do_reset($urandom_range(1, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
